// File: rtl/nes_oam_dma.sv
// NES sprite DMA controller and CPU/DMA bus arbiter: copies one page to the OAM data port while the CPU is halted.
// Optional DMC sample-fetch arbitration is enabled with NES_OAM_DMA_DMC_ARB_EN.
module nes_oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter int unsigned XFER_LEN      = 256
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_nrw,
    output logic        cpu_rdy,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_dout,
    output logic        bus_nrw,
    input  logic [7:0]  bus_din,
    output logic        dma_busy
`ifdef NES_OAM_DMA_DMC_ARB_EN
    ,
    input  logic        dmc_req,
    input  logic [15:0] dmc_addr,
    output logic        dmc_ack,
    output logic [7:0]  dmc_data
`endif
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_t;

    state_t      r_state;
    logic        r_parity;
    logic [7:0]  r_page;
    logic [7:0]  r_idx;
    logic [7:0]  r_latch;
    logic        r_cpu_rdy;
    logic        r_busy;
    logic        w_trigger;

    assign w_trigger = (cpu_nrw == 1'b0) && (cpu_addr == DMA_REG_ADDR);

`ifdef NES_OAM_DMA_DMC_ARB_EN
    logic        r_dmc_only;
    logic        r_dmc_ack;
    logic [7:0]  r_dmc_data;
    logic        w_dmc_hit;

    // A DMC-only claim always spends its single get cycle on the DMC fetch.
    assign w_dmc_hit = (r_state == S_READ) && (dmc_req || r_dmc_only);
    assign dmc_ack   = r_dmc_ack;
    assign dmc_data  = r_dmc_data;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state   <= S_IDLE;
            r_parity  <= 1'b0;
            r_page    <= '0;
            r_idx     <= '0;
            r_latch   <= '0;
            r_cpu_rdy <= 1'b1;
            r_busy    <= 1'b0;
`ifdef NES_OAM_DMA_DMC_ARB_EN
            r_dmc_only <= 1'b0;
            r_dmc_ack  <= 1'b0;
            r_dmc_data <= '0;
`endif
        end else begin
            r_parity <= ~r_parity;
`ifdef NES_OAM_DMA_DMC_ARB_EN
            r_dmc_ack <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_trigger) begin
                        r_page    <= cpu_dout;
                        r_idx     <= '0;
                        r_cpu_rdy <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_HALT;
`ifdef NES_OAM_DMA_DMC_ARB_EN
                        r_dmc_only <= 1'b0;
                    end else if (dmc_req) begin
                        r_cpu_rdy  <= 1'b0;
                        r_busy     <= 1'b1;
                        r_dmc_only <= 1'b1;
                        r_state    <= S_HALT;
`endif
                    end
                end
                S_HALT: begin
                    // parity high now means the next cycle is a get cycle.
                    r_state <= r_parity ? S_READ : S_ALIGN;
                end
                S_ALIGN: begin
                    r_state <= S_READ;
                end
                S_READ: begin
`ifdef NES_OAM_DMA_DMC_ARB_EN
                    if (w_dmc_hit) begin
                        r_dmc_data <= bus_din;
                        r_dmc_ack  <= 1'b1;
                        if (r_dmc_only) begin
                            r_dmc_only <= 1'b0;
                            r_cpu_rdy  <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_state <= S_ALIGN;
                        end
                    end else begin
                        r_latch <= bus_din;
                        r_state <= S_WRITE;
                    end
`else
                    r_latch <= bus_din;
                    r_state <= S_WRITE;
`endif
                end
                S_WRITE: begin
                    if (r_idx == LAST_IDX) begin
                        r_idx     <= '0;
                        r_cpu_rdy <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_idx   <= r_idx + 8'd1;
                        r_state <= S_READ;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus_addr = cpu_addr;
        bus_dout = cpu_dout;
        bus_nrw  = cpu_nrw;
        case (r_state)
            S_ALIGN: begin
                bus_dout = r_latch;
                bus_nrw  = 1'b1;
            end
            S_READ: begin
                bus_addr = {r_page, r_idx};
                bus_dout = r_latch;
                bus_nrw  = 1'b1;
`ifdef NES_OAM_DMA_DMC_ARB_EN
                if (w_dmc_hit) begin
                    bus_addr = dmc_addr;
                end
`endif
            end
            S_WRITE: begin
                bus_addr = OAM_DATA_ADDR;
                bus_dout = r_latch;
                bus_nrw  = 1'b0;
            end
            default: begin
                bus_addr = cpu_addr;
            end
        endcase
    end

    assign cpu_rdy  = r_cpu_rdy;
    assign dma_busy = r_busy;

endmodule

// File: tb/tb_nes_oam_dma.sv
// Randomized bench for nes_oam_dma: a flat memory array feeds bus_din, writes to the OAM port are
// collected and compared with the source page, and halt length is predicted from clock-edge parity.
module tb_nes_oam_dma;

    localparam logic [15:0] DMA_A  = 16'h4014;
    localparam logic [15:0] OAM_A  = 16'h2004;
    localparam logic [15:0] IDLE_A = 16'h0123;

    logic        clk = 1'b0;
    logic        nrst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_nrw;
    logic        cpu_rdy;
    logic [15:0] bus_addr;
    logic [7:0]  bus_dout;
    logic        bus_nrw;
    logic [7:0]  bus_din;
    logic        dma_busy;
`ifdef NES_OAM_DMA_DMC_ARB_EN
    logic        dmc_req = 1'b0;
    logic [15:0] dmc_addr = 16'h0000;
    logic        dmc_ack;
    logic [7:0]  dmc_data;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;

    logic [7:0]  mem [0:65535];
    logic [7:0]  oam_q [$];
    int unsigned edges;

    nes_oam_dma #(
        .DMA_REG_ADDR (DMA_A),
        .OAM_DATA_ADDR(OAM_A),
        .XFER_LEN     (256)
    ) dut (
        .clk     (clk),
        .nrst    (nrst),
        .cpu_addr(cpu_addr),
        .cpu_dout(cpu_dout),
        .cpu_nrw (cpu_nrw),
        .cpu_rdy (cpu_rdy),
        .bus_addr(bus_addr),
        .bus_dout(bus_dout),
        .bus_nrw (bus_nrw),
        .bus_din (bus_din),
        .dma_busy(dma_busy)
`ifdef NES_OAM_DMA_DMC_ARB_EN
        ,
        .dmc_req (dmc_req),
        .dmc_addr(dmc_addr),
        .dmc_ack (dmc_ack),
        .dmc_data(dmc_data)
`endif
    );

    always #5 clk = ~clk;

    assign bus_din = mem[bus_addr];

    // Edges since reset release; the cycle after edge k is a put cycle when k is odd.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) edges <= 0;
        else       edges <= edges + 1;
    end

    always @(negedge clk) begin
        if (nrst && bus_nrw == 1'b0 && bus_addr == OAM_A) oam_q.push_back(bus_dout);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Writes the page value to the DMA register on an edge of the requested parity.
    task automatic do_trigger(input logic [7:0] pg, input bit odd_edge, output int unsigned trig);
        oam_q.delete();
        @(negedge clk); #1;
        if ((((edges + 1) % 2) == 1) != odd_edge) begin
            @(negedge clk); #1;
        end
        cpu_addr = DMA_A;
        cpu_dout = pg;
        cpu_nrw  = 1'b0;
        @(posedge clk); #1;
        trig     = edges;
        cpu_addr = IDLE_A;
        cpu_dout = 8'h00;
        cpu_nrw  = 1'b1;
        check_eq("rdy_drop", {31'd0, cpu_rdy}, 0);
        check_eq("busy_rise", {31'd0, dma_busy}, 1);
    endtask

    // mode 0: plain, 1: CPU retrigger at byte 100, 2: DMC request at byte 10
    task automatic run_xfer(input logic [7:0] pg, input bit odd_edge, input int mode);
        int unsigned trig;
        int unsigned low = 0;
        int unsigned exp_low;
        int unsigned bad_reads = 0;
        int unsigned forced = 0;
        bit finished = 0;
`ifdef NES_OAM_DMA_DMC_ARB_EN
        int unsigned dmc_reads = 0;
        int unsigned acks = 0;
        bit dmc_sent = 0;
`endif
        do_trigger(pg, odd_edge, trig);
        exp_low = 1 + ((trig % 2 == 0) ? 1 : 0) + 2 * 256 + ((mode == 2) ? 2 : 0);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #1;
            if (cpu_rdy) begin
                finished = 1;
                break;
            end
            low++;
            if (bus_nrw && bus_addr[15:8] == 8'h07) bad_reads++;
            if (mode == 1) begin
                if (forced == 0 && oam_q.size() >= 100) begin
                    cpu_addr = DMA_A;
                    cpu_dout = 8'h07;
                    cpu_nrw  = 1'b0;
                    forced   = 1;
                end else if (forced > 0 && forced < 4) begin
                    forced++;
                end else if (forced == 4) begin
                    cpu_addr = IDLE_A;
                    cpu_nrw  = 1'b1;
                    forced   = 5;
                end
            end
`ifdef NES_OAM_DMA_DMC_ARB_EN
            if (bus_nrw && bus_addr == 16'hC000) dmc_reads++;
            if (dmc_ack) begin
                acks++;
                check_eq("dmc_data", {24'd0, dmc_data}, {24'd0, mem[16'hC000]});
                dmc_req = 1'b0;
            end
            if (mode == 2 && !dmc_sent && oam_q.size() >= 10) begin
                dmc_req  = 1'b1;
                dmc_addr = 16'hC000;
                dmc_sent = 1;
            end
`endif
        end
        check_eq("xfer_done", {31'd0, finished}, 1);
        check_eq("halt_cycles", low, exp_low);
        check_eq("busy_fall", {31'd0, dma_busy}, 0);
        check_eq("oam_count", oam_q.size(), 256);
        check_eq("page07_reads", bad_reads, 0);
        for (int i = 0; i < oam_q.size() && i < 256; i++) begin
            check_eq("oam_data", {24'd0, oam_q[i]}, {24'd0, mem[{pg, 8'(i)}]});
        end
`ifdef NES_OAM_DMA_DMC_ARB_EN
        if (mode == 2) begin
            check_eq("dmc_reads", dmc_reads, 1);
            check_eq("dmc_acks", acks, 1);
        end
        dmc_req = 1'b0;
`endif
        cpu_addr = IDLE_A;
        cpu_nrw  = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("oam_after_done", oam_q.size(), 256);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned trig;
        int unsigned n0;
        logic [15:0] a;
        logic [7:0]  d;
        logic        w;
        bit          reached;

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;

        nrst     = 1'b0;
        cpu_addr = 16'h1234;
        cpu_dout = 8'h56;
        cpu_nrw  = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_rdy", {31'd0, cpu_rdy}, 1);
        check_eq("rst_busy", {31'd0, dma_busy}, 0);
        check_eq("rst_addr", {16'd0, bus_addr}, 32'h1234);
        check_eq("rst_dout", {24'd0, bus_dout}, 32'h56);
        check_eq("rst_nrw", {31'd0, bus_nrw}, 1);
        #1 nrst = 1'b1;

        // Idle passthrough: fixed write then random traffic away from the trigger and OAM addresses.
        @(negedge clk); #1;
        cpu_addr = 16'h0300; cpu_dout = 8'hAA; cpu_nrw = 1'b0;
        #1;
        check_eq("pass_addr", {16'd0, bus_addr}, 32'h0300);
        check_eq("pass_dout", {24'd0, bus_dout}, 32'hAA);
        check_eq("pass_nrw", {31'd0, bus_nrw}, 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            a = 16'($urandom_range(0, 16'h1FFF)) | 16'h8000;
            d = 8'($urandom);
            w = 1'($urandom);
            cpu_addr = a; cpu_dout = d; cpu_nrw = w;
            #1;
            check_eq("rnd_addr", {16'd0, bus_addr}, {16'd0, a});
            check_eq("rnd_dout", {24'd0, bus_dout}, {24'd0, d});
            check_eq("rnd_nrw", {31'd0, bus_nrw}, {31'd0, w});
            check_eq("rnd_rdy", {31'd0, cpu_rdy}, 1);
            check_eq("rnd_busy", {31'd0, dma_busy}, 0);
        end
        cpu_addr = IDLE_A; cpu_nrw = 1'b1;

        run_xfer(8'h02, 1'b1, 0);
        run_xfer(8'h02, 1'b0, 0);
        run_xfer(8'h02, 1'($urandom), 1);
        for (int k = 0; k < 2; k++) begin
            run_xfer(8'($urandom_range(8, 255)), 1'($urandom), 0);
        end

        // Reset in the middle of a transfer.
        do_trigger(8'h02, 1'($urandom), trig);
        reached = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk); #1;
            if (oam_q.size() >= 41) begin
                reached = 1;
                break;
            end
        end
        check_eq("reach_byte40", {31'd0, reached}, 1);
        nrst = 1'b0;
        #1;
        check_eq("midrst_rdy", {31'd0, cpu_rdy}, 1);
        check_eq("midrst_busy", {31'd0, dma_busy}, 0);
        check_eq("midrst_addr", {16'd0, bus_addr}, {16'd0, IDLE_A});
        @(negedge clk); #1;
        nrst = 1'b1;
        n0 = oam_q.size();
        repeat (600) @(negedge clk);
        check_eq("no_oam_after_rst", oam_q.size(), n0);
        run_xfer(8'h03, 1'($urandom), 0);

`ifdef NES_OAM_DMA_DMC_ARB_EN
        run_xfer(8'h02, 1'b1, 2);
        run_xfer(8'h02, 1'b0, 2);
        // DMC request while idle: CPU is briefly halted and the fetch is served.
        @(negedge clk); #1;
        dmc_req = 1'b1; dmc_addr = 16'hC000;
        reached = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (dmc_ack) begin
                reached = 1;
                dmc_req = 1'b0;
                check_eq("idle_dmc_data", {24'd0, dmc_data}, {24'd0, mem[16'hC000]});
                break;
            end
        end
        dmc_req = 1'b0;
        check_eq("idle_dmc_ack", {31'd0, reached}, 1);
        check_eq("idle_dmc_rdy", {31'd0, cpu_rdy}, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
